// File: rtl/cdce_serial_writer_if.sv
// Command handshake and SPI-style pins between the command controller, the
// serial writer and the CDCE device.
interface cdce_serial_writer_if #(
    parameter int WORD_WIDTH = 20
);
    logic                  start_transaction;
    logic [WORD_WIDTH-1:0] command;
    logic                  serial_ready;
    logic                  sclk;
    logic                  mosi;
    logic                  le;

    modport master (
        output start_transaction,
        output command,
        input  serial_ready,
        input  sclk,
        input  mosi,
        input  le
    );

    modport slave (
        input  start_transaction,
        input  command,
        output serial_ready,
        output sclk,
        output mosi,
        output le
    );
endinterface

// File: rtl/cdce_serial_writer.sv
// Serial shift engine for the CDCE SPI-style port: captures one command word per
// request, shifts it out on SCLK/MOSI and pulses LE to latch it into the device.
module cdce_serial_writer #(
    parameter int WORD_WIDTH = 20,
    parameter int CLK_DIV    = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    cdce_serial_writer_if.slave  bus
);
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WORD_WIDTH);
    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LOW,
        S_SHIFT_HIGH,
        S_HOLD,
        S_LATCH
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [HW-1:0]         r_hcnt, w_hcnt_nxt;
    logic [BW-1:0]         r_bcnt, w_bcnt_nxt;
    logic [WORD_WIDTH-1:0] r_sreg, w_sreg_nxt;
    logic                  r_ready, w_ready_nxt;
    logic                  r_sclk, w_sclk_nxt;
    logic                  r_mosi, w_mosi_nxt;
    logic                  r_le, w_le_nxt;
    logic                  w_phase_end;
    logic [WORD_WIDTH-1:0] w_shifted;

    function automatic logic first_bit(input logic [WORD_WIDTH-1:0] word);
        return LSB_FIRST ? word[0] : word[WORD_WIDTH-1];
    endfunction

    function automatic logic [WORD_WIDTH-1:0] advance(input logic [WORD_WIDTH-1:0] word);
        return LSB_FIRST ? (word >> 1) : (word << 1);
    endfunction

    assign w_phase_end = (r_hcnt == H_LAST);
    assign w_shifted   = advance(r_sreg);

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = (r_state == S_IDLE || w_phase_end) ? '0 : r_hcnt + HW'(1);
        w_bcnt_nxt  = r_bcnt;
        w_sreg_nxt  = r_sreg;
        w_ready_nxt = r_ready;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_le_nxt    = r_le;
        case (r_state)
            S_IDLE: begin
                if (bus.start_transaction) begin
                    w_state_nxt = S_SHIFT_LOW;
                    w_sreg_nxt  = bus.command;
                    w_mosi_nxt  = first_bit(bus.command);
                    w_bcnt_nxt  = '0;
                    w_ready_nxt = 1'b0;
                    w_le_nxt    = 1'b0;
                    w_sclk_nxt  = 1'b0;
                end
            end
            S_SHIFT_LOW: begin
                if (w_phase_end) begin
                    w_state_nxt = S_SHIFT_HIGH;
                    w_sclk_nxt  = 1'b1;
                end
            end
            S_SHIFT_HIGH: begin
                if (w_phase_end) begin
                    w_sclk_nxt = 1'b0;
                    // mosi only moves on the falling sclk edge, keeping it stable around each rise
                    if (r_bcnt == B_LAST) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_SHIFT_LOW;
                        w_bcnt_nxt  = r_bcnt + BW'(1);
                        w_sreg_nxt  = w_shifted;
                        w_mosi_nxt  = first_bit(w_shifted);
                    end
                end
            end
            S_HOLD: begin
                if (w_phase_end) begin
                    w_state_nxt = S_LATCH;
                    w_le_nxt    = 1'b1;
                    w_mosi_nxt  = 1'b0;
                end
            end
            S_LATCH: begin
                if (w_phase_end) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
            r_ready <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_le    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_ready <= w_ready_nxt;
            r_sclk  <= w_sclk_nxt;
            r_mosi  <= w_mosi_nxt;
            r_le    <= w_le_nxt;
        end
    end

    // The shift register is pure data and is always reloaded on capture.
    always_ff @(posedge i_clk) begin
        r_sreg <= w_sreg_nxt;
    end

    assign bus.serial_ready = r_ready;
    assign bus.sclk         = r_sclk;
    assign bus.mosi         = r_mosi;
    assign bus.le           = r_le;
endmodule

// File: tb/tb_cdce_serial_writer.sv
// Bench for cdce_serial_writer: two instances (LSB-first H=4, MSB-first H=1),
// queued expected words and a pin-level monitor that decodes what the device sees.
module tb_cdce_serial_writer;
    localparam int W  = 20;
    localparam int HA = 4;
    localparam int HB = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cdce_serial_writer_if #(.WORD_WIDTH(W)) busA ();
    cdce_serial_writer_if #(.WORD_WIDTH(W)) busB ();

    cdce_serial_writer #(.WORD_WIDTH(W), .CLK_DIV(HA), .LSB_FIRST(1'b1)) dutA (
        .i_clk(clk), .i_reset(reset), .bus(busA)
    );
    cdce_serial_writer #(.WORD_WIDTH(W), .CLK_DIV(HB), .LSB_FIRST(1'b0)) dutB (
        .i_clk(clk), .i_reset(reset), .bus(busB)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [W-1:0] qA[$];
    logic [W-1:0] qB[$];
    bit abortA = 0;
    bit b2bA   = 0;

    // Reference order: LSB-first means the n-th bit on the wire is word[n].
    function automatic int bit_pos(input int n, input bit lsb);
        return lsb ? n : (W - 1 - n);
    endfunction

    // ---------------- monitor A ----------------
    logic [W-1:0] rxA_w = '0;
    int rxA_n = 0, leLowA = 0, leHighA = 0, sinceKA = 0;
    logic pSclkA = 0, pLeA = 1, pRdyA = 1, pMosiA = 0;
    bit mosiBadA = 0;

    always @(negedge clk) begin
        logic [W-1:0] expw;
        bit le_rise;
        leLowA++; leHighA++; sinceKA++;
        le_rise = busA.le && !pLeA;
        if (busA.sclk && !pSclkA) begin
            if (rxA_n < W) rxA_w[bit_pos(rxA_n, 1'b1)] = busA.mosi;
            rxA_n++;
        end
        if (busA.sclk && pSclkA && busA.mosi !== pMosiA) mosiBadA = 1;
        if (!busA.le && pLeA) begin
            chk("A_ready_while_le_low", busA.serial_ready, 0);
            if (b2bA) begin
                chk("A_le_gap", leHighA, HA + 1);
                b2bA = 0;
            end
            leLowA = 0; rxA_n = 0; rxA_w = '0; mosiBadA = 0;
        end
        if (le_rise) begin
            chk("A_word_pending", int'(qA.size() > 0), 1);
            expw = (qA.size() > 0) ? qA.pop_front() : '0;
            if (abortA) begin
                chk("A_abort_short", int'(rxA_n < W), 1);
            end else begin
                chk("A_word", rxA_w, expw);
                chk("A_rises", rxA_n, W);
                chk("A_le_low", leLowA, (2 * W + 1) * HA);
                chk("A_mosi_stable", mosiBadA, 0);
            end
            leHighA = 0;
        end
        if (busA.serial_ready && !pRdyA && !abortA)
            chk("A_ready_latency", sinceKA, (2 * W + 2) * HA);
        if (!busA.serial_ready && pRdyA) sinceKA = 0;
        if (le_rise) abortA = 0;
        pSclkA = busA.sclk; pLeA = busA.le; pRdyA = busA.serial_ready; pMosiA = busA.mosi;
    end

    // ---------------- monitor B ----------------
    logic [W-1:0] rxB_w = '0;
    int rxB_n = 0, leLowB = 0, sinceKB = 0;
    logic pSclkB = 0, pLeB = 1, pRdyB = 1;

    always @(negedge clk) begin
        logic [W-1:0] expw;
        leLowB++; sinceKB++;
        if (busB.sclk && !pSclkB) begin
            if (rxB_n < W) rxB_w[bit_pos(rxB_n, 1'b0)] = busB.mosi;
            rxB_n++;
        end
        if (!busB.le && pLeB) begin
            leLowB = 0; rxB_n = 0; rxB_w = '0;
        end
        if (busB.le && !pLeB) begin
            chk("B_word_pending", int'(qB.size() > 0), 1);
            expw = (qB.size() > 0) ? qB.pop_front() : '0;
            chk("B_word", rxB_w, expw);
            chk("B_rises", rxB_n, W);
            chk("B_le_low", leLowB, (2 * W + 1) * HB);
        end
        if (busB.serial_ready && !pRdyB) chk("B_ready_latency", sinceKB, (2 * W + 2) * HB);
        if (!busB.serial_ready && pRdyB) sinceKB = 0;
        pSclkB = busB.sclk; pLeB = busB.le; pRdyB = busB.serial_ready;
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input bit b, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (b ? busB.serial_ready : busA.serial_ready) begin
                ok = 1;
                break;
            end
        end
        chk("ready_wait", ok, 1);
    endtask

    task automatic send(input bit b, input logic [W-1:0] w);
        bit ok;
        wait_ready(b, ok);
        if (b) begin busB.start_transaction = 1; busB.command = w; end
        else   begin busA.start_transaction = 1; busA.command = w; end
        @(posedge clk);
        if (ok) begin
            if (b) qB.push_back(w); else qA.push_back(w);
        end
        #1;
        busA.start_transaction = 0;
        busB.start_transaction = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, busA.serial_ready, 1);
        chk({tag, "_sclk"},  busA.sclk, 0);
        chk({tag, "_mosi"},  busA.mosi, 0);
        chk({tag, "_le"},    busA.le, 1);
    endtask

    initial begin
        bit ok;
        logic [W-1:0] w;
        busA.start_transaction = 0; busA.command = '0;
        busB.start_transaction = 0; busB.command = '0;
        reset = 1;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst_init");
        chk("rst_init_B_ready", busB.serial_ready, 1);
        @(negedge clk) reset = 0;
        repeat (3) @(negedge clk);

        // reset while idle
        @(posedge clk); #2 reset = 1;
        #1 check_reset_outputs("rst_idle");
        @(negedge clk) reset = 0;
        repeat (2) @(negedge clk);

        // single word
        send(0, 20'hA5C3F);

        // ignored second request mid-word
        send(0, 20'hA5C3F);
        repeat (9) @(negedge clk);
        chk("A_busy_ready", busA.serial_ready, 0);
        busA.start_transaction = 1; busA.command = 20'h12345;
        @(negedge clk);
        busA.start_transaction = 0;

        // start held high -> back-to-back words
        wait_ready(0, ok);
        busA.start_transaction = 1; busA.command = 20'h00001;
        @(posedge clk); qA.push_back(20'h00001);
        @(negedge clk) busA.command = 20'h80000;
        wait_ready(0, ok);
        @(posedge clk); qA.push_back(20'h80000);
        #1 b2bA = 1;
        busA.start_transaction = 0;

        // reset during bit 7, then a clean word
        send(0, 20'hFFFFF);
        repeat (57) @(posedge clk);
        #2 abortA = 1; reset = 1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        @(negedge clk) reset = 0;
        send(0, 20'h0F0F0);

        // random words with random gaps and stray mid-word requests
        for (int i = 0; i < 6; i++) begin
            w = W'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(0, w);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 100)) @(negedge clk);
                busA.start_transaction = 1; busA.command = W'($urandom);
                @(negedge clk);
                busA.start_transaction = 0;
            end
        end

        // MSB-first, one clk per half-period
        send(1, 20'h80001);
        for (int i = 0; i < 3; i++) send(1, W'($urandom));

        wait_ready(0, ok);
        wait_ready(1, ok);
        repeat (3) @(negedge clk);
        chk("A_queue_drained", qA.size(), 0);
        chk("B_queue_drained", qB.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1);
    end
endmodule
